pm_rspndr: RTL

Program-memory responder: the memory end of the sequencer's instruction-fetch interface (`ps_pm_cslt`, `ps_pm_wrb`, `ps_pm_add` in; `pm_ps_op` out). It serves registered 32-bit instruction words with one-cycle latency. It also owns a boot-loader port that fills the array through a valid/ready handshake before execution starts. While loading, and for any invalid fetch, it returns the NOP word `32'h0000_0000`, so the sequencer never decodes garbage.

---
 rtl/pm_pkg.sv | 15 +
 rtl/pm_ram.sv | 34 +++
 rtl/pm_rspndr.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pm_pkg.sv
// rtl/pm_pkg.sv - shared constants and state type for the program-memory responder
package pm_pkg;

    localparam int PM_DEPTH_DEF  = 1024;
    localparam int PM_ADDR_W_DEF = 16;
    localparam int PM_DATA_W_DEF = 32;

    localparam logic [31:0] PM_NOP = 32'h0000_0000;

    typedef enum logic {
        PM_LOAD = 1'b0,
        PM_RUN  = 1'b1
    } pm_state_t;

endpackage

// File: rtl/pm_ram.sv
// rtl/pm_ram.sv - DEPTH x W array, one synchronous write port, one synchronous read port
//
// Ports:
//   clk            clock
//   we/waddr/wdata write port (shared by loader and sequencer, muxed in the top)
//   re/raddr       read request; rdata updates on the edge where re is high, holds otherwise
//   rdata          registered read word
module pm_ram #(
    parameter  int DEPTH = 1024,
    parameter  int W     = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pm_rspndr.sv
// rtl/pm_rspndr.sv - program-memory responder: boot loader fill, then 1-cycle instruction fetch
//
// Optional feature macro: PM_PARITY_EN (even parity per stored word, checked on read).
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   ps_pm_cslt/wrb/add/wdt       sequencer access: select, write strobe, word address, write data
//   pm_ps_op                     registered instruction word (NOP while loading / on bad fetch)
//   ld_start                     reload request, honoured in RUN only
//   ld_valid/ld_data/ld_last     loader word stream; ld_ready is the accept side
//   pm_boot_done                 high while in RUN
//   pm_err                       sticky range / overflow (/ parity) error, cleared by reset only
module pm_rspndr
    import pm_pkg::*;
#(
    parameter int DEPTH  = PM_DEPTH_DEF,
    parameter int ADDR_W = PM_ADDR_W_DEF,
    parameter int DATA_W = PM_DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ps_pm_cslt,
    input  logic              ps_pm_wrb,
    input  logic [ADDR_W-1:0] ps_pm_add,
    input  logic [DATA_W-1:0] ps_pm_wdt,
    output logic [DATA_W-1:0] pm_ps_op,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              pm_boot_done,
    output logic              pm_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
`ifdef PM_PARITY_EN
    localparam int RAM_W = DATA_W + 1;
`else
    localparam int RAM_W = DATA_W;
`endif

    pm_state_t         state, state_next;
    logic [AW-1:0]     ld_cnt;
    logic              nop_q;       // output currently shows NOP rather than the RAM word
    logic              rd_valid_q;  // RAM read register was refreshed at the last edge

    logic              in_range;
    logic              seq_rd, seq_wr;
    logic              ld_fire, ld_overflow;
    logic              ram_we, ram_re;
    logic [AW-1:0]     ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [RAM_W-1:0]  wr_word, rd_word;
    logic              par_bad;

    assign in_range    = {1'b0, ps_pm_add} < DEPTH_EXT;
    assign seq_rd      = ps_pm_cslt && !ps_pm_wrb;
    assign seq_wr      = ps_pm_cslt &&  ps_pm_wrb;
    assign ld_fire     = ld_valid && ld_ready;
    assign ld_overflow = ld_fire && !ld_last && (ld_cnt == AW'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= PM_LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        ld_ready     = 1'b0;
        pm_boot_done = 1'b0;
        ram_we       = 1'b0;
        ram_waddr    = ps_pm_add[AW-1:0];
        ram_wdata    = ps_pm_wdt;
        ram_re       = 1'b0;
        case (state)
            PM_LOAD: begin
                ld_ready  = 1'b1;
                ram_we    = ld_valid;
                ram_waddr = ld_cnt;
                ram_wdata = ld_data;
                if (ld_valid && (ld_last || ld_cnt == AW'(DEPTH - 1))) begin
                    state_next = PM_RUN;
                end
            end
            PM_RUN: begin
                pm_boot_done = 1'b1;
                ram_we       = seq_wr && in_range;
                ram_re       = seq_rd && in_range;
                if (ld_start) begin
                    state_next = PM_LOAD;
                end
            end
            default: state_next = PM_LOAD;
        endcase
    end

`ifdef PM_PARITY_EN
    assign wr_word = {^ram_wdata, ram_wdata};
    assign par_bad = ^rd_word;
`else
    assign wr_word = ram_wdata;
    assign par_bad = 1'b0;
`endif

    pm_ram #(.DEPTH(DEPTH), .W(RAM_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (wr_word),
        .re    (ram_re),
        .raddr (ps_pm_add[AW-1:0]),
        .rdata (rd_word)
    );

    // The RAM read register carries the word; nop_q and the parity check pick NOP instead.
    // Both only change on a fresh read, so the output holds when no read is made.
    assign pm_ps_op = (nop_q || par_bad) ? DATA_W'(PM_NOP) : rd_word[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_cnt     <= '0;
            nop_q      <= 1'b1;
            rd_valid_q <= 1'b0;
            pm_err     <= 1'b0;
        end else begin
            rd_valid_q <= ram_re;
            if (state == PM_LOAD) begin
                if (ld_fire) begin
                    ld_cnt <= ld_cnt + AW'(1);
                end
                if (seq_rd) begin
                    nop_q <= 1'b1;
                end
                if (ld_overflow) begin
                    pm_err <= 1'b1;
                end
            end else begin
                if (ld_start) begin
                    ld_cnt <= '0;
                end
                if (seq_rd) begin
                    nop_q <= !in_range;
                end
                if (ps_pm_cslt && !in_range) begin
                    pm_err <= 1'b1;
                end
            end
            if (rd_valid_q && par_bad) begin
                pm_err <= 1'b1;
            end
        end
    end

endmodule
